cache_req_arbiter: RTL and testbench

Parametrised multi-channel cache request port. It accepts cache operations (opcode, address, write data) from NUM_CH requesters, each through a valid/ready handshake into a per-channel FIFO. It arbitrates round-robin onto a single registered downstream cache port tagged with the channel ID, and routes returning responses back to the originating channel. It sits between the trace/CPU-side requesters and the cache controller, replacing the bare untimed operation/addr/data bundle with a buffered, back-pressured interface.

---
 rtl/cache_req_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cache_req_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// Multi-channel cache request port: per-channel FIFOs, round-robin arbiter onto a registered
// downstream port, and registered response routing. Define CACHE_ARB_PRIO_EN for channel-0 strict priority.
module cache_req_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int OP_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH*OP_W-1:0]   ch_op,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_rsp_valid,
  output logic [DATA_W-1:0]        ch_rsp_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OP_W-1:0]          m_op,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  output logic [CH_W-1:0]          m_ch,
  input  logic                     rsp_valid,
  input  logic [CH_W-1:0]          rsp_ch,
  input  logic [DATA_W-1:0]        rsp_data
);

  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int AW    = PW - 1;
  localparam int ENT_W = OP_W + ADDR_W + DATA_W;
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  logic [ENT_W-1:0]  mem  [NUM_CH][DEPTH];
  logic [PW-1:0]     wptr [NUM_CH];
  logic [PW-1:0]     rptr [NUM_CH];
  logic [NUM_CH-1:0] empty, full, push, pop;

  logic [NUM_CH-1:0] elig, rr_elig;
  logic [CH_W-1:0]   last_grant, rr_ch, gnt_ch, cand;
  logic              prio_win, rr_found, gnt_any, load_en;
  logic [ENT_W-1:0]  head;

  logic              m_valid_p1;
  logic [OP_W-1:0]   m_op_p1;
  logic [ADDR_W-1:0] m_addr_p1;
  logic [DATA_W-1:0] m_wdata_p1;
  logic [CH_W-1:0]   m_ch_p1;
  logic [NUM_CH-1:0] rsp_vld_p0;
  logic [DATA_W-1:0] rsp_data_p0;
  logic              rsp_hit;

  // p0: per-channel FIFOs; the extra pointer MSB separates full from empty
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i] = (wptr[i] == rptr[i]);
      full[i]  = (wptr[i][PW-1] != rptr[i][PW-1]) && (wptr[i][AW-1:0] == rptr[i][AW-1:0]);
    end
  end

  assign ch_ready = ~full;
  assign push     = ch_valid & ch_ready;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mem[i][wptr[i][AW-1:0]] <= {ch_op[i*OP_W +: OP_W], ch_addr[i*ADDR_W +: ADDR_W],
                                    ch_wdata[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
      end
    end
  end

  // arbitration between FIFO heads and the output register
  assign elig    = ~empty;
  assign load_en = !m_valid_p1 || m_ready;
`ifdef CACHE_ARB_PRIO_EN
  assign prio_win = elig[0];
  assign rr_elig  = {elig[NUM_CH-1:1], 1'b0};
`else
  assign prio_win = 1'b0;
  assign rr_elig  = elig;
`endif

  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!rr_found && rr_elig[cand]) begin
        rr_found = 1'b1;
        rr_ch    = cand;
      end
    end
  end

  assign gnt_any = load_en && (prio_win || rr_found);
  assign gnt_ch  = prio_win ? '0 : rr_ch;
  assign head    = mem[gnt_ch][rptr[gnt_ch][AW-1:0]];

  always_comb begin
    pop = '0;
    if (gnt_any) pop[gnt_ch] = 1'b1;
  end

  // p1: downstream output register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_valid_p1 <= 1'b0;
      last_grant <= LAST_CH;
    end else if (load_en) begin
      m_valid_p1 <= gnt_any;
      if (gnt_any && !prio_win) last_grant <= gnt_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_op_p1    <= '0;
      m_addr_p1  <= '0;
      m_wdata_p1 <= '0;
      m_ch_p1    <= '0;
    end else if (gnt_any) begin
      {m_op_p1, m_addr_p1, m_wdata_p1} <= head;
      m_ch_p1 <= gnt_ch;
    end
  end

  assign m_valid = m_valid_p1;
  assign m_op    = m_op_p1;
  assign m_addr  = m_addr_p1;
  assign m_wdata = m_wdata_p1;
  assign m_ch    = m_ch_p1;

  // p0: response routing; out-of-range channel ids are dropped
  assign rsp_hit = rsp_valid && ({1'b0, rsp_ch} < NUM_CH_V);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_vld_p0  <= '0;
      rsp_data_p0 <= '0;
    end else begin
      rsp_vld_p0 <= '0;
      if (rsp_hit) begin
        rsp_vld_p0[rsp_ch] <= 1'b1;
        rsp_data_p0        <= rsp_data;
      end
    end
  end

  assign ch_rsp_valid = rsp_vld_p0;
  assign ch_rsp_data  = rsp_data_p0;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the FIFOs, arbiter and response path.
module tb_cache_req_arbiter;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int OP_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
  localparam int CH_W   = 2;
  localparam int N3     = 3;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_CH-1:0]        ch_valid, ch_ready, ch_rsp_valid;
  logic [NUM_CH*OP_W-1:0]   ch_op;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [DATA_W-1:0]        ch_rsp_data;
  logic                     m_valid, m_ready;
  logic [OP_W-1:0]          m_op;
  logic [ADDR_W-1:0]        m_addr;
  logic [DATA_W-1:0]        m_wdata;
  logic [CH_W-1:0]          m_ch;
  logic                     rsp_valid;
  logic [CH_W-1:0]          rsp_ch;
  logic [DATA_W-1:0]        rsp_data;

  // three-channel instance: exercises dropping of rsp_ch values beyond NUM_CH-1
  logic [N3-1:0]        ch_valid3, ch_ready3, ch_rsp_valid3;
  logic [N3*OP_W-1:0]   ch_op3;
  logic [N3*ADDR_W-1:0] ch_addr3;
  logic [N3*DATA_W-1:0] ch_wdata3;
  logic [DATA_W-1:0]    ch_rsp_data3;
  logic                 m_valid3, m_ready3;
  logic [OP_W-1:0]      m_op3;
  logic [ADDR_W-1:0]    m_addr3;
  logic [DATA_W-1:0]    m_wdata3;
  logic [CH_W-1:0]      m_ch3;

  always #5 clk = ~clk;

  cache_req_arbiter #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .OP_W(OP_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_op(ch_op),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata), .m_ch(m_ch),
    .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data));

  cache_req_arbiter #(.NUM_CH(N3), .DEPTH(DEPTH), .OP_W(OP_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut3 (
    .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid3), .ch_ready(ch_ready3), .ch_op(ch_op3),
    .ch_addr(ch_addr3), .ch_wdata(ch_wdata3), .ch_rsp_valid(ch_rsp_valid3), .ch_rsp_data(ch_rsp_data3),
    .m_valid(m_valid3), .m_ready(m_ready3), .m_op(m_op3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_ch(m_ch3),
    .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data));

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // reference model state
  req_t              q [NUM_CH][$];
  bit                mdl_mv;
  req_t              mdl_m;
  int                mdl_mch;
  int                mdl_lg;
  bit [NUM_CH-1:0]   mdl_rspv;
  logic [DATA_W-1:0] mdl_rspd;

  int n_chk = 0;
  int n_pass = 0;

  function automatic int pick();
    int g;
    g = -1;
`ifdef CACHE_ARB_PRIO_EN
    if (q[0].size() > 0) return 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (g < 0 && ((mdl_lg + k) % NUM_CH) != 0 && q[(mdl_lg + k) % NUM_CH].size() > 0)
        g = (mdl_lg + k) % NUM_CH;
    end
`else
    for (int k = 1; k <= NUM_CH; k++) begin
      if (g < 0 && q[(mdl_lg + k) % NUM_CH].size() > 0) g = (mdl_lg + k) % NUM_CH;
    end
`endif
    return g;
  endfunction

  // one clock edge for DUT and model; returns at posedge+1
  task automatic tick();
    bit [NUM_CH-1:0]   acc;
    req_t              pend [NUM_CH];
    int                g;
    bit                can_load, rst_now;
    bit [NUM_CH-1:0]   nrv;
    logic [DATA_W-1:0] nrd;
    rst_now = !reset_n;
    for (int i = 0; i < NUM_CH; i++) begin
      acc[i]  = ch_valid[i] && (q[i].size() < DEPTH);
      pend[i] = {ch_op[i*OP_W +: OP_W], ch_addr[i*ADDR_W +: ADDR_W], ch_wdata[i*DATA_W +: DATA_W]};
    end
    can_load = !mdl_mv || m_ready;
    g = can_load ? pick() : -1;
    nrv = '0;
    nrd = mdl_rspd;
    if (rsp_valid && int'(rsp_ch) < NUM_CH) begin
      nrv[rsp_ch] = 1'b1;
      nrd = rsp_data;
    end
    @(posedge clk);
    if (rst_now) begin
      for (int i = 0; i < NUM_CH; i++) q[i].delete();
      mdl_mv = 1'b0; mdl_m = '0; mdl_mch = 0; mdl_lg = NUM_CH - 1;
      mdl_rspv = '0; mdl_rspd = '0;
    end else begin
      if (can_load) begin
        if (g >= 0) begin
          mdl_m = q[g].pop_front();
          mdl_mch = g;
          mdl_mv = 1'b1;
`ifdef CACHE_ARB_PRIO_EN
          if (g != 0) mdl_lg = g;
`else
          mdl_lg = g;
`endif
        end else begin
          mdl_mv = 1'b0;
        end
      end
      for (int i = 0; i < NUM_CH; i++) if (acc[i]) q[i].push_back(pend[i]);
      mdl_rspv = nrv;
      mdl_rspd = nrd;
    end
    #1;
  endtask

  task automatic set_req(input int c, input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd);
    ch_op[c*OP_W +: OP_W]        = op;
    ch_addr[c*ADDR_W +: ADDR_W]  = addr;
    ch_wdata[c*DATA_W +: DATA_W] = wd;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ch_valid = '0; rsp_valid = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    n_chk++;
    if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
    n_chk++;
    if ({m_op, m_addr, m_wdata, m_ch} !== '0)
      $display("FAIL reset_m_payload: got %h want 0", {m_op, m_addr, m_wdata, m_ch}); else n_pass++;
    n_chk++;
    if (ch_ready !== 4'b1111) $display("FAIL reset_ch_ready: got %b want 1111", ch_ready); else n_pass++;
    n_chk++;
    if ({ch_rsp_valid, ch_rsp_data} !== '0)
      $display("FAIL reset_rsp: got %h want 0", {ch_rsp_valid, ch_rsp_data}); else n_pass++;
    n_chk++;
    if ({m_valid3, m_op3, m_addr3, m_wdata3, m_ch3, ch_rsp_valid3, ch_rsp_data3} !== '0 || ch_ready3 !== 3'b111)
      $display("FAIL reset_dut3: got %h ready %b want 0 ready 111",
               {m_valid3, m_op3, m_addr3, m_wdata3, m_ch3, ch_rsp_valid3, ch_rsp_data3}, ch_ready3);
    else n_pass++;
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    ch_valid = 4'b0001;
    set_req(0, 4'h1, 32'h0000_1000, 8'hAB);
    tick();
    ch_valid = '0;
    n_chk++;
    if (m_valid !== 1'b0) $display("FAIL single_lat1: m_valid got %b want 0", m_valid); else n_pass++;
    n_chk++;
    if (ch_ready[0] !== 1'b1) $display("FAIL single_ready_a: got %b want 1", ch_ready[0]); else n_pass++;
    tick();
    n_chk++;
    if ({m_valid, m_op, m_addr, m_wdata, m_ch} !== {1'b1, 4'h1, 32'h0000_1000, 8'hAB, 2'd0})
      $display("FAIL single_out: got %h want %h", {m_valid, m_op, m_addr, m_wdata, m_ch},
               {1'b1, 4'h1, 32'h0000_1000, 8'hAB, 2'd0});
    else n_pass++;
    n_chk++;
    if (ch_ready[0] !== 1'b1) $display("FAIL single_ready_b: got %b want 1", ch_ready[0]); else n_pass++;
    tick();
    n_chk++;
    if (m_valid !== 1'b0) $display("FAIL single_drain: m_valid got %b want 0", m_valid); else n_pass++;
  endtask

  task automatic test_all_channels();
    int exp_seq[12];
    int got[$];
    bit gap;
    int budget;
`ifdef CACHE_ARB_PRIO_EN
    exp_seq = '{0, 0, 0, 1, 2, 3, 1, 2, 3, 1, 2, 3};
`else
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif
    gap = 1'b0;
    do_reset();
    m_ready = 1'b1;
    budget = 0;
    while (got.size() < 12 && budget < 40) begin
      ch_valid = (budget < 3) ? 4'b1111 : 4'b0000;
      for (int c = 0; c < NUM_CH; c++)
        set_req(c, OP_W'(budget + 1), ADDR_W'(32'h2000 + c * 16 + budget), DATA_W'(c * 16 + budget));
      tick();
      budget++;
      if (m_valid) begin
        got.push_back(int'(m_ch));
        n_chk++;
        if ({m_op, m_addr, m_wdata} !== mdl_m)
          $display("FAIL rr_payload[%0d]: got %h want %h", got.size() - 1, {m_op, m_addr, m_wdata}, mdl_m);
        else n_pass++;
      end else if (got.size() > 0) begin
        gap = 1'b1;
      end
    end
    ch_valid = '0;
    n_chk++;
    if (got.size() != 12) $display("FAIL rr_count: got %0d grants want 12", got.size()); else n_pass++;
    for (int k = 0; k < got.size(); k++) begin
      n_chk++;
      if (got[k] != exp_seq[k]) $display("FAIL rr_seq[%0d]: got ch %0d want ch %0d", k, got[k], exp_seq[k]);
      else n_pass++;
    end
    n_chk++;
    if (gap) $display("FAIL rr_idle: got idle cycle want back-to-back"); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] addrs[6];
    logic [ADDR_W-1:0] seen[$];
    int acc;
    bit a;
    do_reset();
    for (int j = 0; j < 6; j++) addrs[j] = ADDR_W'(32'h3000 + j * 4 + ($urandom & 32'hFFF0_0000));
    acc = 0;
    m_ready = 1'b0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      ch_valid = (acc < 6) ? 4'b0100 : 4'b0000;
      set_req(2, OP_W'(acc), addrs[acc < 6 ? acc : 5], DATA_W'(acc));
      a = ch_valid[2] && ch_ready[2];
      tick();
      if (a) acc++;
      if (m_valid) begin
        n_chk++;
        if ({m_addr, m_ch} !== {addrs[0], 2'd2})
          $display("FAIL bp_stable[%0d]: got %h want %h", cyc, {m_addr, m_ch}, {addrs[0], 2'd2});
        else n_pass++;
      end
    end
    n_chk++;
    if (acc != 5) $display("FAIL bp_accepted: got %0d want 5", acc); else n_pass++;
    n_chk++;
    if (ch_ready[2] !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", ch_ready[2]); else n_pass++;
    n_chk++;
    if (m_valid !== 1'b1) $display("FAIL bp_m_valid: got %b want 1", m_valid); else n_pass++;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 25 && seen.size() < 6; cyc++) begin
      ch_valid = (acc < 6) ? 4'b0100 : 4'b0000;
      set_req(2, OP_W'(acc), addrs[acc < 6 ? acc : 5], DATA_W'(acc));
      a = ch_valid[2] && ch_ready[2];
      if (m_valid && m_ready) seen.push_back(m_addr);
      tick();
      if (a) acc++;
    end
    ch_valid = '0;
    n_chk++;
    if (seen.size() != 6) $display("FAIL bp_drain_count: got %0d want 6", seen.size()); else n_pass++;
    for (int j = 0; j < seen.size(); j++) begin
      n_chk++;
      if (seen[j] !== addrs[j]) $display("FAIL bp_order[%0d]: got %h want %h", j, seen[j], addrs[j]);
      else n_pass++;
    end
    n_chk++;
    if (ch_ready[2] !== 1'b1) $display("FAIL bp_ready_recover: got %b want 1", ch_ready[2]); else n_pass++;
  endtask

  task automatic test_response();
    rsp_valid = 1'b1; rsp_ch = 2'd3; rsp_data = 8'h5A;
    tick();
    rsp_valid = 1'b0;
    n_chk++;
    if ({ch_rsp_valid, ch_rsp_data} !== {4'b1000, 8'h5A})
      $display("FAIL rsp_ch3: got %b/%h want 1000/5a", ch_rsp_valid, ch_rsp_data); else n_pass++;
    n_chk++;
    if (ch_rsp_valid3 !== 3'b000) $display("FAIL rsp_drop: got %b want 000", ch_rsp_valid3); else n_pass++;
    tick();
    n_chk++;
    if (ch_rsp_valid !== 4'b0000) $display("FAIL rsp_pulse: got %b want 0000", ch_rsp_valid); else n_pass++;
    rsp_valid = 1'b1; rsp_ch = 2'd2; rsp_data = 8'hC3;
    tick();
    rsp_valid = 1'b0;
    n_chk++;
    if ({ch_rsp_valid3, ch_rsp_data3} !== {3'b100, 8'hC3})
      $display("FAIL rsp3_ch2: got %b/%h want 100/c3", ch_rsp_valid3, ch_rsp_data3); else n_pass++;
    n_chk++;
    if (ch_rsp_valid !== 4'b0100) $display("FAIL rsp_ch2: got %b want 0100", ch_rsp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      ch_valid = 4'b1111;
      for (int c = 0; c < NUM_CH; c++) set_req(c, OP_W'(r), ADDR_W'(32'h4000 + c * 16 + r), DATA_W'(r));
      tick();
    end
    ch_valid = '0;
    tick();
    n_chk++;
    if ({m_valid, m_ch} !== {1'b1, 2'd0}) $display("FAIL mid_pre: got %b/%0d want 1/0", m_valid, m_ch);
    else n_pass++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_chk++;
    if ({m_valid, ch_ready} !== {1'b0, 4'b1111})
      $display("FAIL mid_reset: got %b/%b want 0/1111", m_valid, ch_ready); else n_pass++;
    m_ready = 1'b1;
    ch_valid = 4'b1001;
    set_req(0, 4'h7, 32'h5000, 8'h10);
    set_req(3, 4'h8, 32'h5003, 8'h13);
    tick();
    ch_valid = '0;
    tick();
    n_chk++;
    if ({m_valid, m_ch, m_addr} !== {1'b1, 2'd0, 32'h5000})
      $display("FAIL mid_first_grant: got %b/%0d/%h want 1/0/5000", m_valid, m_ch, m_addr); else n_pass++;
    tick();
    n_chk++;
    if ({m_valid, m_ch, m_addr} !== {1'b1, 2'd3, 32'h5003})
      $display("FAIL mid_second_grant: got %b/%0d/%h want 1/3/5003", m_valid, m_ch, m_addr); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] exp_rdy;
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset_n   = ($urandom_range(0, 149) != 0);
      ch_valid  = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) set_req(c, OP_W'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      m_ready   = ($urandom_range(0, 3) != 0);
      rsp_valid = 1'($urandom_range(0, 1));
      rsp_ch    = CH_W'($urandom);
      rsp_data  = DATA_W'($urandom);
      for (int c = 0; c < NUM_CH; c++) exp_rdy[c] = (q[c].size() < DEPTH);
      n_chk++;
      if (ch_ready !== exp_rdy) $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, ch_ready, exp_rdy);
      else n_pass++;
      tick();
      n_chk++;
      if (m_valid !== mdl_mv) $display("FAIL rnd_m_valid[%0d]: got %b want %b", cyc, m_valid, mdl_mv);
      else n_pass++;
      if (mdl_mv) begin
        n_chk++;
        if ({m_op, m_addr, m_wdata, m_ch} !== {mdl_m, CH_W'(mdl_mch)})
          $display("FAIL rnd_payload[%0d]: got %h want %h", cyc, {m_op, m_addr, m_wdata, m_ch},
                   {mdl_m, CH_W'(mdl_mch)});
        else n_pass++;
      end
      n_chk++;
      if (ch_rsp_valid !== mdl_rspv) $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", cyc, ch_rsp_valid, mdl_rspv);
      else n_pass++;
      if (mdl_rspv != '0) begin
        n_chk++;
        if (ch_rsp_data !== mdl_rspd) $display("FAIL rnd_rsp_data[%0d]: got %h want %h", cyc, ch_rsp_data, mdl_rspd);
        else n_pass++;
      end
    end
    reset_n = 1'b1; ch_valid = '0; rsp_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ch_valid = '0; ch_op = '0; ch_addr = '0; ch_wdata = '0; m_ready = 1'b0;
    rsp_valid = 1'b0; rsp_ch = '0; rsp_data = '0;
    ch_valid3 = '0; ch_op3 = '0; ch_addr3 = '0; ch_wdata3 = '0; m_ready3 = 1'b0;
    mdl_mv = 1'b0; mdl_m = '0; mdl_mch = 0; mdl_lg = NUM_CH - 1; mdl_rspv = '0; mdl_rspd = '0;
    test_reset();
    test_single();
    test_all_channels();
    test_backpressure();
    test_response();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
